neuron_layer_seq: RTL and testbench

- Time-multiplexed fully-connected layer: one signed MAC serves NC neurons over an NP-element input vector.
- Each neuron computes y[c] = sat(((bias[c] << FRAC) + sum_p w[c][p]*x[p]) >> FRAC), with optional ReLU in hidden mode.
- Successor to the parallel per-layer neuron. It adds signed fixed point, on-chip weight/bias storage with a load port, saturation and a selectable activation.
- Sits between layers on the same valid/ready streaming interfaces.

---
 rtl/neuron_layer_seq.sv | 136 +++++++++++++
 tb/tb_neuron_layer_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/neuron_layer_seq.sv
// neuron_layer_seq: time-multiplexed fully-connected layer, one signed MAC shared by NC neurons.
// Optional round-half-up in the output shift is enabled by defining NEURON_ROUND_EN.
module neuron_layer_seq #(
  parameter string HIDDEN = "yes",
  parameter int    NP     = 4,
  parameter int    NC     = 4,
  parameter int    WD     = 8,
  parameter int    FRAC   = 4,
  parameter int    AW     = 2*WD+$clog2(NP+1)+1
) (
  input  logic                             iCLK,
  input  logic                             iRST,
  input  logic                             iValid_AS,
  output logic                             oReady_AS,
  input  logic [NP*WD-1:0]                 iData_AS,
  output logic                             oValid_BS,
  input  logic                             iReady_BS,
  output logic [NC*WD-1:0]                 oData_BS,
  input  logic                             iWe,
  input  logic [$clog2(NC*(NP+1))-1:0]     iWAddr,
  input  logic [WD-1:0]                    iWData,
  output logic                             oWeReady
);
  localparam int NW  = NC*(NP+1);
  localparam int ABW = $clog2(NW);
  localparam int CW  = NC > 1 ? $clog2(NC) : 1;
  localparam int PW  = NP > 1 ? $clog2(NP) : 1;
  localparam bit RELU = (HIDDEN == "yes");
  localparam logic signed [AW-1:0] MAXV = (AW'(1) <<< (WD-1)) - AW'(1);
  localparam logic signed [AW-1:0] MINV = -(AW'(1) <<< (WD-1));
`ifdef NEURON_ROUND_EN
  localparam logic signed [AW-1:0] RND = FRAC > 0 ? AW'(1) <<< (FRAC > 0 ? FRAC-1 : 0) : '0;
`else
  localparam logic signed [AW-1:0] RND = '0;
`endif

  typedef enum logic [1:0] {IDLE, MAC, STORE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           c_q, c_d;
  logic [PW-1:0]           p_q, p_d;
  logic signed [AW-1:0]    acc_q, acc_d, r;
  logic [NP*WD-1:0]        x_q, x_d;
  logic [NC*WD-1:0]        y_q, y_d;
  logic [WD-1:0]           mem_q [NW];
  logic [ABW-1:0]          widx, bnidx;
  logic signed [WD-1:0]    x_cur, w_cur, b0, b_next, sat, res;
  logic signed [2*WD-1:0]  prod;
  logic                    last_c, idle;

  function automatic logic signed [AW-1:0] bext(input logic signed [WD-1:0] b);
    return {{(AW-WD){b[WD-1]}}, b} <<< FRAC;
  endfunction

  assign idle      = (state_q == IDLE);
  assign oReady_AS = idle;
  assign oWeReady  = idle;
  assign oValid_BS = (state_q == DONE);
  assign oData_BS  = y_q;

  // Datapath: operand fetch, product, shifted/saturated/activated result of the current neuron
  always_comb begin
    last_c = (c_q == CW'(NC-1));
    widx   = ABW'(int'(c_q)*(NP+1) + int'(p_q));
    bnidx  = last_c ? ABW'(NP) : ABW'(int'(c_q)*(NP+1) + 2*NP+1);
    x_cur  = x_q[int'(p_q)*WD +: WD];
    w_cur  = mem_q[widx];
    prod   = x_cur * w_cur;
    b0     = (iWe && iWAddr == ABW'(NP)) ? iWData : mem_q[NP];
    b_next = mem_q[bnidx];
    r      = (acc_q + RND) >>> FRAC;
    sat    = r > MAXV ? MAXV[WD-1:0] : r < MINV ? MINV[WD-1:0] : r[WD-1:0];
    res    = (RELU && sat[WD-1]) ? '0 : sat;
  end

  // Next-state logic for the accept/MAC/store/handoff sequence
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    p_d     = p_q;
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE: if (iValid_AS) begin
        x_d     = iData_AS;
        c_d     = '0;
        p_d     = '0;
        acc_d   = bext(b0);
        state_d = MAC;
      end
      MAC: begin
        acc_d   = acc_q + {{(AW-2*WD){prod[2*WD-1]}}, prod};
        p_d     = (p_q == PW'(NP-1)) ? '0 : p_q + PW'(1);
        state_d = (p_q == PW'(NP-1)) ? STORE : MAC;
      end
      STORE: begin
        y_d[int'(c_q)*WD +: WD] = res;
        c_d     = last_c ? c_q : c_q + CW'(1);
        p_d     = '0;
        acc_d   = last_c ? acc_q : bext(b_next);
        state_d = last_c ? DONE : MAC;
      end
      DONE: state_d = iReady_BS ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // Control and datapath registers
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= IDLE;
      c_q     <= '0;
      p_q     <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      p_q     <= p_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Weight/bias store, writable only while idle; out-of-range addresses are dropped
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      for (int i = 0; i < NW; i++) mem_q[i] <= '0;
    end else if (iWe && idle && 32'(iWAddr) < NW) begin
      mem_q[iWAddr] <= iWData;
    end
  end
endmodule

// File: tb/tb_neuron_layer_seq.sv
// tb_neuron_layer_seq: directed checks of the sequential layer in linear and ReLU builds.
`timescale 1ns/1ps
module tb_neuron_layer_seq;
  logic        clk = 0, rst_n = 0;
  logic        iValid = 0, iReady = 1, iWe = 0;
  logic [31:0] iData = '0;
  logic [4:0]  iWAddr = '0;
  logic [7:0]  iWData = '0;
  logic        rdy_n, vld_n, wer_n, rdy_h, vld_h, wer_h;
  logic [31:0] dat_n, dat_h;
  int          n_cmp = 0, n_bad = 0, n = 0;

  always #5 clk = ~clk;

  neuron_layer_seq #(.HIDDEN("no")) dut_n (
    .iCLK(clk), .iRST(rst_n), .iValid_AS(iValid), .oReady_AS(rdy_n), .iData_AS(iData),
    .oValid_BS(vld_n), .iReady_BS(iReady), .oData_BS(dat_n),
    .iWe(iWe), .iWAddr(iWAddr), .iWData(iWData), .oWeReady(wer_n));

  neuron_layer_seq #(.HIDDEN("yes")) dut_h (
    .iCLK(clk), .iRST(rst_n), .iValid_AS(iValid), .oReady_AS(rdy_h), .iData_AS(iData),
    .oValid_BS(vld_h), .iReady_BS(iReady), .oData_BS(dat_h),
    .iWe(iWe), .iWAddr(iWAddr), .iWData(iWData), .oWeReady(wer_h));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    iWe = 1; iWAddr = 5'(a); iWData = d;
    @(negedge clk);
    iWe = 0;
  endtask

  task automatic load(input logic [7:0] w, input logic [7:0] b);
    for (int c = 0; c < 4; c++)
      for (int p = 0; p <= 4; p++) wr(c*5+p, p == 4 ? b : w);
  endtask

  task automatic start(input logic [31:0] x);
    iData = x; iValid = 1;
    @(negedge clk);
    iValid = 0;
  endtask

  task automatic wait_done();
    n = 1;
    while (!vld_n && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("valid_reached", {31'b0, vld_n}, 32'd1);
  endtask

  task automatic run(input logic [31:0] x);
    start(x);
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    #1;
    chk("rst_ready", {31'b0, rdy_n}, 32'd1);
    chk("rst_valid", {31'b0, vld_n}, 32'd0);
    chk("rst_data", dat_n, 32'h0);
    chk("rst_weready", {31'b0, wer_n}, 32'd1);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // passthrough with backpressure: w=16, b=0, x={16,32,-16,0} -> 32 each
    load(8'd16, 8'd0);
    iReady = 0;
    start(32'h00F0_2010);
    wait_done();
    chk("latency", n, 32'd21);
    chk("pass_n", dat_n, 32'h2020_2020);
    chk("pass_h", dat_h, 32'h2020_2020);
    for (int i = 0; i < 5; i++) begin
      iValid = 1; iData = 32'h1111_1111;
      @(negedge clk);
      chk("bp_valid", {31'b0, vld_n}, 32'd1);
      chk("bp_data", dat_n, 32'h2020_2020);
      chk("bp_ready", {31'b0, rdy_n}, 32'd0);
      chk("bp_weready", {31'b0, wer_n}, 32'd0);
    end
    iValid = 0; iReady = 1;
    @(negedge clk);
    chk("rel_valid", {31'b0, vld_n}, 32'd0);
    chk("rel_ready", {31'b0, rdy_n}, 32'd1);
    @(negedge clk);
    chk("rel_idle_valid", {31'b0, vld_n}, 32'd0);
    chk("rel_keep_data", dat_n, 32'h2020_2020);

    // write while busy is dropped
    start(32'h00F0_2010);
    @(negedge clk);
    iWe = 1; iWAddr = 5'd0; iWData = 8'd5;
    #1;
    chk("busy_weready", {31'b0, wer_n}, 32'd0);
    chk("busy_ready", {31'b0, rdy_n}, 32'd0);
    @(negedge clk);
    iWe = 0;
    wait_done();
    chk("busy_result", dat_n, 32'h2020_2020);
    @(negedge clk);

    // saturation high
    load(8'd127, 8'd0);
    run(32'h7F7F_7F7F);
    chk("sat_hi_n", dat_n, 32'h7F7F_7F7F);
    chk("sat_hi_h", dat_h, 32'h7F7F_7F7F);

    // saturation low, ReLU clamps
    load(8'h80, 8'd0);
    run(32'h7F7F_7F7F);
    chk("sat_lo_n", dat_n, 32'h8080_8080);
    chk("sat_lo_h", dat_h, 32'h0000_0000);

    // bias only
    load(8'd0, 8'd1);
    run(32'h0000_0000);
    chk("bias_n", dat_n, 32'h0101_0101);
    chk("bias_h", dat_h, 32'h0101_0101);

    // rounding: 1*8 = 0.5 in Q4
    load(8'd0, 8'd0);
    for (int c = 0; c < 4; c++) wr(c*5, 8'd8);
    run(32'h0000_0001);
`ifdef NEURON_ROUND_EN
    chk("round_n", dat_n, 32'h0101_0101);
`else
    chk("round_n", dat_n, 32'h0000_0000);
`endif

    // reset mid-MAC clears outputs and weights
    load(8'd16, 8'd2);
    start(32'h1010_1010);
    repeat (6) @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", {31'b0, vld_n}, 32'd0);
    chk("mid_rst_ready", {31'b0, rdy_n}, 32'd1);
    chk("mid_rst_data", dat_n, 32'h0);
    chk("mid_rst_weready", {31'b0, wer_n}, 32'd1);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run(32'h1010_1010);
    chk("post_rst_n", dat_n, 32'h0);
    chk("post_rst_h", dat_h, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
